// File: rtl/mem_access_ctrl.sv
// Single-request data-memory access controller: IDLE -> ACCESS (strobe held WAIT_CYCLES) -> DONE.
// Define MEM_ACCESS_CTRL_RANGE_CHECK_EN to reject aligned addresses at or above 32'h80.
module mem_access_ctrl #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        memread_o,
   output logic        memwrite_o,
   output logic [31:0] memaddr_o,
   output logic [31:0] writedata_o,
   input  logic [31:0] memdata_i
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [4:0]  word_q, word_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        bad_addr;

`ifdef MEM_ACCESS_CTRL_RANGE_CHECK_EN
   assign bad_addr = (addr_i[1:0] != 2'b00) || (addr_i >= 32'h80);
`else
   // Upper address bits only matter when the range check is built in.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_i[31:7];
   assign bad_addr       = (addr_i[1:0] != 2'b00);
`endif

   // NOTE: every _d gets its hold value first, so no path through the case leaves one unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               we_d    = we_i;
               word_d  = addr_i[6:2];
               wdata_d = wdata_i;
               cnt_d   = 4'd0;
               err_d   = bad_addr;
               state_d = bad_addr ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               if (!we_q) rdata_d = memdata_i;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         word_q  <= 5'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // err_q is only ever set on the way into DONE and cleared on the way out.
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign err_o       = err_q;
   assign rdata_o     = rdata_q;
   assign memread_o   = (state_q == ACCESS) && !we_q;
   assign memwrite_o  = (state_q == ACCESS) && we_q;
   assign memaddr_o   = {27'b0, word_q};
   assign writedata_o = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (WAIT_CYCLES=2) with a 32-word data memory beside it.
// Inputs change and outputs are checked on the falling edge.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_i, req_i, we_i;
   logic [31:0] addr_i, wdata_i;
   logic        busy_o, done_o, err_o, memread_o, memwrite_o;
   logic [31:0] rdata_o, memaddr_o, writedata_o, memdata_i;

   logic        pre_we;
   logic [4:0]  pre_addr;
   logic [31:0] pre_data;
   logic [31:0] mem [32];

   int checks = 0;
   int errors = 0;
   int done_cnt;
   int wr_seen;

   always #5 clk = ~clk;

   mem_access_ctrl #(.WAIT_CYCLES(2)) dut (
      .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
      .err_o(err_o), .rdata_o(rdata_o), .memread_o(memread_o),
      .memwrite_o(memwrite_o), .memaddr_o(memaddr_o),
      .writedata_o(writedata_o), .memdata_i(memdata_i)
   );

   always @(posedge clk) begin
      if (pre_we)          mem[pre_addr] <= pre_data;
      else if (memwrite_o) mem[memaddr_o[4:0]] <= writedata_o;
   end
   assign memdata_i = mem[memaddr_o[4:0]];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Pulse a request for one cycle; returns in cycle N+1.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
      tick();
      req_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0C; wdata_i = 32'h0;
      pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'h0;
      tick(); tick();
      // reset with a simultaneous request
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_done", {31'b0, done_o}, 32'd0);
      check("rst_err", {31'b0, err_o}, 32'd0);
      check("rst_strobes", {30'b0, memread_o, memwrite_o}, 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      check("rst_memaddr", memaddr_o, 32'd0);

      req_i = 1'b0; rst_i = 1'b1;
      pre_we = 1'b1; pre_addr = 5'd3; pre_data = 32'hDEADBEEF;
      tick();
      pre_addr = 5'd1; pre_data = 32'hCAFEF00D;
      tick();
      pre_we = 1'b0;
      check("idle_busy", {31'b0, busy_o}, 32'd0);

      // load word 3
      issue(1'b0, 32'h0C, 32'h0);
      check("ld_rd_n1", {31'b0, memread_o}, 32'd1);
      check("ld_wr_n1", {31'b0, memwrite_o}, 32'd0);
      check("ld_addr_n1", memaddr_o, 32'd3);
      check("ld_busy_n1", {31'b0, busy_o}, 32'd1);
      check("ld_done_n1", {31'b0, done_o}, 32'd0);
      tick();
      check("ld_rd_n2", {31'b0, memread_o}, 32'd1);
      check("ld_addr_n2", memaddr_o, 32'd3);
      tick();
      check("ld_rd_n3", {31'b0, memread_o}, 32'd0);
      check("ld_done_n3", {31'b0, done_o}, 32'd1);
      check("ld_err_n3", {31'b0, err_o}, 32'd0);
      check("ld_rdata", rdata_o, 32'hDEADBEEF);
      tick();
      check("ld_done_n4", {31'b0, done_o}, 32'd0);
      check("ld_busy_n4", {31'b0, busy_o}, 32'd0);

      // store to word 4, rdata untouched
      issue(1'b1, 32'h10, 32'h12345678);
      check("st_wr_n1", {31'b0, memwrite_o}, 32'd1);
      check("st_rd_n1", {31'b0, memread_o}, 32'd0);
      check("st_addr_n1", memaddr_o, 32'd4);
      check("st_wdata_n1", writedata_o, 32'h12345678);
      tick();
      check("st_wr_n2", {31'b0, memwrite_o}, 32'd1);
      check("st_addr_n2", memaddr_o, 32'd4);
      check("st_rdata_n2", rdata_o, 32'hDEADBEEF);
      tick();
      check("st_wr_n3", {31'b0, memwrite_o}, 32'd0);
      check("st_done_n3", {31'b0, done_o}, 32'd1);
      check("st_rdata_n3", rdata_o, 32'hDEADBEEF);
      tick();

      // load back word 4
      issue(1'b0, 32'h10, 32'h0);
      tick(); tick();
      check("ld2_done", {31'b0, done_o}, 32'd1);
      check("ld2_rdata", rdata_o, 32'h12345678);
      tick();

      // misaligned address
      issue(1'b0, 32'h06, 32'h0);
      check("mis_done", {31'b0, done_o}, 32'd1);
      check("mis_err", {31'b0, err_o}, 32'd1);
      check("mis_strobes", {30'b0, memread_o, memwrite_o}, 32'd0);
      tick();
      check("mis_err_after", {31'b0, err_o}, 32'd0);
      check("mis_busy_after", {31'b0, busy_o}, 32'd0);

      // second request while busy is dropped
      issue(1'b0, 32'h0C, 32'h0);
      req_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; wdata_i = 32'hFFFFFFFF;
      tick();
      req_i = 1'b0;
      done_cnt = 0; wr_seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (done_o) done_cnt++;
         if (memwrite_o) wr_seen++;
         tick();
      end
      check("drop_done_cnt", done_cnt, 32'd1);
      check("drop_no_write", wr_seen, 32'd0);
      check("drop_rdata", rdata_o, 32'hDEADBEEF);
      check("drop_mem4", mem[4], 32'h12345678);

      // reset during ACCESS aborts the load
      issue(1'b0, 32'h10, 32'h0);
      check("abort_rd_n1", {31'b0, memread_o}, 32'd1);
      rst_i = 1'b0;
      tick();
      check("abort_strobes", {30'b0, memread_o, memwrite_o}, 32'd0);
      check("abort_busy", {31'b0, busy_o}, 32'd0);
      check("abort_done", {31'b0, done_o}, 32'd0);
      check("abort_rdata", rdata_o, 32'd0);
      rst_i = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done_o || busy_o) done_cnt++;
      end
      check("abort_quiet", done_cnt, 32'd0);

      // address above the 32-word window
      issue(1'b0, 32'h84, 32'h0);
`ifdef MEM_ACCESS_CTRL_RANGE_CHECK_EN
      check("range_done", {31'b0, done_o}, 32'd1);
      check("range_err", {31'b0, err_o}, 32'd1);
      check("range_strobes", {30'b0, memread_o, memwrite_o}, 32'd0);
`else
      check("range_rd", {31'b0, memread_o}, 32'd1);
      check("range_addr", memaddr_o, 32'd1);
      tick(); tick();
      check("range_done", {31'b0, done_o}, 32'd1);
      check("range_err", {31'b0, err_o}, 32'd0);
      check("range_rdata", rdata_o, 32'hCAFEF00D);
`endif
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
